// File: rtl/tdc_seq_pkg.sv
// Shared TDC7200 register map, SPI frame geometry and sequencer state encoding.
// Contents: WR_BIT, REG_* addresses, WR_LEN/RD_LEN, frame indices, state_t.
// Optional macro TDC_CAL_READ_EN: when defined, the CALIB1/CALIB2 read frames are part of the sequence.
package tdc_seq_pkg;

  // The first byte of a frame is {rw, addr}. Bit 6 set means write. Reads leave it clear.
  localparam logic [7:0] WR_BIT         = 8'h40;

  localparam logic [7:0] REG_CONFIG1    = 8'h00;
  localparam logic [7:0] REG_CONFIG2    = 8'h01;
  localparam logic [7:0] REG_INT_STATUS = 8'h02;
  localparam logic [7:0] REG_INT_MASK   = 8'h03;
  localparam logic [7:0] REG_COARSE_H   = 8'h04;
  localparam logic [7:0] REG_COARSE_L   = 8'h05;
  localparam logic [7:0] REG_CLOCK_H    = 8'h06;
  localparam logic [7:0] REG_CLOCK_L    = 8'h07;
  localparam logic [7:0] REG_STOPMSK_H  = 8'h08;
  localparam logic [7:0] REG_STOPMSK_L  = 8'h09;
  localparam logic [7:0] REG_TIME1      = 8'h10;
  localparam logic [7:0] REG_CALIB1     = 8'h1B;
  localparam logic [7:0] REG_CALIB2     = 8'h1C;

  // Write frames carry 2 bytes: cmd and data.
  // Read frames carry 4 bytes: cmd and a 24-bit register.
  localparam int WR_LEN = 2;
  localparam int RD_LEN = 4;

  // Frame indices into the command ROM.
  localparam logic [3:0] FRM_CONFIG1 = 4'd9;
  localparam logic [3:0] FRM_TIME1   = 4'd10;
`ifdef TDC_CAL_READ_EN
  localparam logic [3:0] FRM_LAST    = 4'd12;
`else
  localparam logic [3:0] FRM_LAST    = FRM_TIME1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tdc_cmd_seq_if.sv
// SPI byte-stream handshake between the command sequencer and the SPI shifter.
// Signals: out_data/out_last/out_rd/out_ch travel with out_valid. out_ready is returned.
// Modports: master (sequencer side), slave (shifter side).
interface tdc_cmd_seq_if #(
  parameter int NUM_CH = 2
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           out_rd;
  logic [CHW-1:0] out_ch;

  modport master (output out_data, out_valid, out_last, out_rd, out_ch,
                  input  out_ready);
  modport slave  (input  out_data, out_valid, out_last, out_rd, out_ch,
                  output out_ready);
endinterface

// File: rtl/tdc_cmd_rom.sv
// Combinational command table: maps a (frame, byte) index to {byte, last, rd}.
// Ports: i_frame/i_byte index in. o_byte, o_last (final byte of the frame) and o_rd (MISO carries data) out.
// Parameters: COARSE_OVF (written to regs 0x04/0x05) and CONFIG1_START (the measurement trigger).
module tdc_cmd_rom
  import tdc_seq_pkg::*;
#(
  parameter logic [15:0] COARSE_OVF    = 16'h018F,
  parameter logic [7:0]  CONFIG1_START = 8'h81
) (
  input  logic [3:0] i_frame,
  input  logic [1:0] i_byte,
  output logic [7:0] o_byte,
  output logic       o_last,
  output logic       o_rd
);
  logic [7:0] w_reg;
  logic [7:0] w_wdat;
  logic       w_is_rd;

  always_comb begin
    w_reg   = 8'h00;
    w_wdat  = 8'h00;
    w_is_rd = 1'b0;
    case (i_frame)
      4'd0:  begin w_reg = REG_CONFIG2;   w_wdat = 8'h40;            end
      4'd1:  begin w_reg = REG_INT_STATUS; w_wdat = 8'h00;           end
      4'd2:  begin w_reg = REG_INT_MASK;  w_wdat = 8'h07;            end
      4'd3:  begin w_reg = REG_COARSE_H;  w_wdat = COARSE_OVF[15:8]; end
      4'd4:  begin w_reg = REG_COARSE_L;  w_wdat = COARSE_OVF[7:0];  end
      4'd5:  begin w_reg = REG_CLOCK_H;   w_wdat = 8'hFF;            end
      4'd6:  begin w_reg = REG_CLOCK_L;   w_wdat = 8'hFF;            end
      4'd7:  begin w_reg = REG_STOPMSK_H; w_wdat = 8'h00;            end
      4'd8:  begin w_reg = REG_STOPMSK_L; w_wdat = 8'h00;            end
      4'd9:  begin w_reg = REG_CONFIG1;   w_wdat = CONFIG1_START;    end
      4'd10: begin w_reg = REG_TIME1;     w_is_rd = 1'b1;            end
      4'd11: begin w_reg = REG_CALIB1;    w_is_rd = 1'b1;            end
      4'd12: begin w_reg = REG_CALIB2;    w_is_rd = 1'b1;            end
      default: ;
    endcase

    if (w_is_rd) begin
      // The host clocks out zero bytes while the chip shifts back the register.
      o_byte = (i_byte == 2'd0) ? w_reg : 8'h00;
      o_last = (i_byte == 2'(RD_LEN - 1));
      o_rd   = (i_byte != 2'd0);
    end else begin
      o_byte = (i_byte == 2'd0) ? (WR_BIT | w_reg) : w_wdat;
      o_last = (i_byte == 2'(WR_LEN - 1));
      o_rd   = 1'b0;
    end
  end
endmodule

// File: rtl/tdc_cmd_seq.sv
// TDC7200 configure-and-measure SPI command sequencer.
// Ports: clk/rst (sync, active-high). start/mode/ch/abort control in.
//        bus (tdc_cmd_seq_if.master) byte stream out. busy/done/aborted/err status out.
// Optional macro TDC_CAL_READ_EN: when defined, CALIB1/CALIB2 reads are appended after TIME1.
module tdc_cmd_seq
  import tdc_seq_pkg::*;
#(
  parameter int          NUM_CH        = 2,
  parameter logic [15:0] COARSE_OVF    = 16'h018F,
  parameter int          GAP_CYC       = 2,
  parameter logic [7:0]  CONFIG1_START = 8'h81,
  localparam int         CHW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic [CHW-1:0]  ch,
  input  logic            abort,
  tdc_cmd_seq_if.master   bus,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            err
);
  localparam int            GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_frame, w_frame_nxt;
  logic [1:0]     r_byte,  w_byte_nxt;
  logic [GW-1:0]  r_gap,   w_gap_nxt;
  logic [CHW-1:0] r_ch,    w_ch_nxt;
  logic           r_err,   w_err_nxt;
  logic           r_abt,   w_abt_nxt;

  logic [7:0]     w_rom_byte;
  logic           w_rom_last;
  logic           w_rom_rd;
  logic           w_valid;

  tdc_cmd_rom #(
    .COARSE_OVF    (COARSE_OVF),
    .CONFIG1_START (CONFIG1_START)
  ) u_rom (
    .i_frame (r_frame),
    .i_byte  (r_byte),
    .o_byte  (w_rom_byte),
    .o_last  (w_rom_last),
    .o_rd    (w_rom_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_frame <= '0;
      r_byte  <= '0;
      r_gap   <= '0;
      r_ch    <= '0;
      r_err   <= 1'b0;
      r_abt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_frame <= w_frame_nxt;
      r_byte  <= w_byte_nxt;
      r_gap   <= w_gap_nxt;
      r_ch    <= w_ch_nxt;
      r_err   <= w_err_nxt;
      r_abt   <= w_abt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_byte_nxt  = r_byte;
    w_gap_nxt   = r_gap;
    w_ch_nxt    = r_ch;
    w_err_nxt   = 1'b0;
    w_abt_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // An abort in the same cycle cancels the start before it takes effect.
        if (start && !abort) begin
          if (int'(ch) >= NUM_CH) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_SEND;
            w_ch_nxt    = ch;
            // Mode is consumed here: it only selects the entry frame.
            w_frame_nxt = mode ? FRM_CONFIG1 : 4'd0;
            w_byte_nxt  = 2'd0;
          end
        end
      end
      ST_SEND: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_abt_nxt   = 1'b1;
          w_frame_nxt = '0;
          w_byte_nxt  = '0;
        end else if (bus.out_ready) begin
          if (w_rom_last) begin
            w_byte_nxt = '0;
            if (r_frame == FRM_LAST) begin
              w_state_nxt = ST_DONE;
              w_frame_nxt = '0;
            end else begin
              w_state_nxt = ST_GAP;
              w_frame_nxt = r_frame + 4'd1;
              w_gap_nxt   = '0;
            end
          end else begin
            w_byte_nxt = r_byte + 2'd1;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_abt_nxt   = 1'b1;
          w_frame_nxt = '0;
          w_gap_nxt   = '0;
        end else if (r_gap == GAP_LAST) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      // The sequence has already completed, so an abort here has nothing to cancel.
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The outputs decode registered state through the ROM. They therefore hold steady during stalls.
  assign w_valid       = (r_state == ST_SEND);
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? w_rom_byte : 8'h00;
  assign bus.out_last  = w_valid & w_rom_last;
  assign bus.out_rd    = w_valid & w_rom_rd;
  assign bus.out_ch    = r_ch;
  assign busy          = (r_state == ST_SEND) || (r_state == ST_GAP);
  assign done          = (r_state == ST_DONE);
  assign aborted       = r_abt;
  assign err           = r_err;
endmodule
